// File: rtl/match_sequencer.sv
// Pong match controller: sequences serve, play, point, pause and game over,
// keeps both scores and latches the AI difficulty for the running match.
module match_sequencer #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 50_000_000,
   parameter int POINT_PAUSE = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause_btn,
   input  logic [1:0] diff_sel,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       game_on,
   output logic       serve,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [1:0] diff,
   output logic [1:0] winner,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      POINT      = 3'd3,
      PAUSED     = 3'd4,
      GAME_OVER  = 3'd5
   } state_t;

   localparam logic [31:0] SERVE_LAST = 32'(SERVE_DELAY - 1);
   localparam logic [31:0] POINT_LAST = 32'(POINT_PAUSE - 1);
   localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

   state_t      st_q, st_d;
   state_t      ret_q, ret_d;
   logic [31:0] cnt_q, cnt_d;
   logic        start_q, pause_q;
   logic        start_e, pause_e;
   logic [3:0]  sl_d, sr_d;
   logic [1:0]  win_d, diff_d;
   logic        dir_d, serve_d, game_on_d;

   assign start_e = start & ~start_q;
   assign pause_e = pause_btn & ~pause_q;
   assign state   = st_q;

   // Next-state and next-output logic for the match sequence
   always_comb begin
      st_d    = st_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      sl_d    = score_left;
      sr_d    = score_right;
      win_d   = winner;
      diff_d  = diff;
      dir_d   = serve_dir;
      serve_d = 1'b0;
      unique case (st_q)
         IDLE: begin
            diff_d = diff_sel;
            if (start_e) begin
               st_d  = SERVE_WAIT;
               sl_d  = 4'd0;
               sr_d  = 4'd0;
               win_d = 2'b00;
               cnt_d = 32'd0;
            end
         end
         SERVE_WAIT: begin
            if (pause_e) begin
               st_d  = PAUSED;
               ret_d = SERVE_WAIT;
            end else if (cnt_q == SERVE_LAST) begin
               st_d    = PLAY;
               serve_d = 1'b1;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         PLAY: begin
            if (miss_left | miss_right) begin
               st_d  = POINT;
               cnt_d = 32'd0;
               if (miss_left & miss_right) begin
                  dir_d = ~serve_dir;
               end else if (miss_left) begin
                  dir_d = 1'b0;
                  if (score_right < WIN) sr_d = score_right + 4'd1;
               end else begin
                  dir_d = 1'b1;
                  if (score_left < WIN) sl_d = score_left + 4'd1;
               end
            end else if (pause_e) begin
               st_d  = PAUSED;
               ret_d = PLAY;
            end
         end
         POINT: begin
            if (cnt_q == POINT_LAST) begin
               cnt_d = 32'd0;
               if (score_left == WIN) begin
                  st_d  = GAME_OVER;
                  win_d = 2'b01;
               end else if (score_right == WIN) begin
                  st_d  = GAME_OVER;
                  win_d = 2'b10;
               end else begin
                  st_d = SERVE_WAIT;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         PAUSED: begin
            if (pause_e) st_d = ret_q;
         end
         GAME_OVER: begin
            if (start_e) begin
               st_d   = SERVE_WAIT;
               sl_d   = 4'd0;
               sr_d   = 4'd0;
               win_d  = 2'b00;
               diff_d = diff_sel;
               cnt_d  = 32'd0;
            end
         end
         default: st_d = IDLE;
      endcase
      game_on_d = (st_d == SERVE_WAIT) || (st_d == PLAY);
   end

   // State, counter, score and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q        <= IDLE;
         ret_q       <= SERVE_WAIT;
         cnt_q       <= 32'd0;
         start_q     <= 1'b1;
         pause_q     <= 1'b1;
         score_left  <= 4'd0;
         score_right <= 4'd0;
         winner      <= 2'b00;
         diff        <= diff_sel;
         serve_dir   <= 1'b0;
         serve       <= 1'b0;
         game_on     <= 1'b0;
      end else begin
         st_q        <= st_d;
         ret_q       <= ret_d;
         cnt_q       <= cnt_d;
         start_q     <= start;
         pause_q     <= pause_btn;
         score_left  <= sl_d;
         score_right <= sr_d;
         winner      <= win_d;
         diff        <= diff_d;
         serve_dir   <= dir_d;
         serve       <= serve_d;
         game_on     <= game_on_d;
      end
   end

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match scenarios plus random stimulus,
// checked every cycle against a countdown-based behavioural model.
module tb_match_sequencer;

   localparam int W  = 3;
   localparam int SD = 4;
   localparam int PP = 3;

   logic       clk = 1'b0;
   logic       reset, start, pause_btn, miss_left, miss_right;
   logic [1:0] diff_sel;
   logic       game_on, serve, serve_dir;
   logic [3:0] score_left, score_right;
   logic [1:0] diff, winner;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // model state
   int       m_phase, m_ret, m_left, m_sl, m_sr, m_win;
   bit       m_dir, m_serve, m_ps, m_pp;
   bit [1:0] m_diff;

   match_sequencer #(
      .WIN_SCORE(W), .SERVE_DELAY(SD), .POINT_PAUSE(PP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pause_btn(pause_btn),
      .diff_sel(diff_sel), .miss_left(miss_left), .miss_right(miss_right),
      .game_on(game_on), .serve(serve), .serve_dir(serve_dir),
      .score_left(score_left), .score_right(score_right),
      .diff(diff), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   task automatic new_match(input bit [1:0] ds);
      m_phase = 1;
      m_left  = SD;
      m_sl    = 0;
      m_sr    = 0;
      m_win   = 0;
      m_diff  = ds;
   endtask

   task automatic model_step(input bit rst, input bit s, input bit p,
                             input bit [1:0] ds, input bit ml,
                             input bit mr);
      bit se, pe;
      if (rst) begin
         m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0;
         m_serve = 0; m_dir = 0; m_diff = ds;
         m_ps = 1; m_pp = 1; m_left = 0; m_ret = 1;
         return;
      end
      se = s && !m_ps;
      pe = p && !m_pp;
      m_ps = s;
      m_pp = p;
      m_serve = 0;
      case (m_phase)
         0: begin
            m_diff = ds;
            if (se) new_match(ds);
         end
         1: begin
            if (pe) begin
               m_ret = 1; m_phase = 4;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2; m_serve = 1;
               end
            end
         end
         2: begin
            if (ml || mr) begin
               m_phase = 3; m_left = PP;
               if (ml && mr) m_dir = !m_dir;
               else if (ml) begin
                  m_dir = 0;
                  if (m_sr < W) m_sr++;
               end else begin
                  m_dir = 1;
                  if (m_sl < W) m_sl++;
               end
            end else if (pe) begin
               m_ret = 2; m_phase = 4;
            end
         end
         3: begin
            m_left--;
            if (m_left == 0) begin
               if (m_sl == W) begin
                  m_phase = 5; m_win = 1;
               end else if (m_sr == W) begin
                  m_phase = 5; m_win = 2;
               end else begin
                  m_phase = 1; m_left = SD;
               end
            end
         end
         4: if (pe) m_phase = m_ret;
         5: if (se) new_match(ds);
         default: m_phase = 0;
      endcase
   endtask

   task automatic tick();
      bit r, s, p, ml, mr;
      bit [1:0] ds;
      r = reset; s = start; p = pause_btn;
      ml = miss_left; mr = miss_right; ds = diff_sel;
      @(posedge clk);
      model_step(r, s, p, ds, ml, mr);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_to_play();
      for (int i = 0; i < 30 && m_phase != 2; i++) tick();
      chk("reach_play", 32'(state), 32'd2);
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [17:0] e, a;
      if (chk_en) begin
         e = {(m_phase == 1 || m_phase == 2), m_serve, m_dir,
              4'(m_sl), 4'(m_sr), m_diff, 2'(m_win), 3'(m_phase)};
         a = {game_on, serve, serve_dir, score_left, score_right,
              diff, winner, state};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t: got %h expected %h",
                     $time, a, e);
         end
      end
   end

   initial begin
      reset = 1; start = 0; pause_btn = 0;
      miss_left = 0; miss_right = 0; diff_sel = 2'd1;
      repeat (3) tick();
      chk_en = 1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_game_on", 32'(game_on), 32'd0);
      chk("rst_diff", 32'(diff), 32'd1);
      reset = 0;
      repeat (2) tick();

      // 1: start and serve timing
      start = 1; tick(); start = 0;
      chk("t1_serve_wait", 32'(state), 32'd1);
      repeat (3) tick();
      chk("t1_still_wait", 32'(state), 32'd1);
      chk("t1_game_on_w", 32'(game_on), 32'd1);
      tick();
      chk("t1_play", 32'(state), 32'd2);
      chk("t1_serve", 32'(serve), 32'd1);
      tick();
      chk("t1_serve_off", 32'(serve), 32'd0);
      chk("t1_game_on", 32'(game_on), 32'd1);

      // 2: left miss scores for right
      repeat (2) tick();
      miss_left = 1; tick(); miss_left = 0;
      chk("t2_sr", 32'(score_right), 32'd1);
      chk("t2_point", 32'(state), 32'd3);
      chk("t2_game_off", 32'(game_on), 32'd0);
      chk("t2_dir", 32'(serve_dir), 32'd0);
      chk("t2_model_left", 32'(m_left), 32'd3);
      repeat (2) tick();
      chk("t2_point_hold", 32'(state), 32'd3);
      tick();
      chk("t2_reserve", 32'(state), 32'd1);

      // 3: simultaneous misses
      run_to_play();
      miss_left = 1; miss_right = 1; tick();
      miss_left = 0; miss_right = 0;
      chk("t3_sl", 32'(score_left), 32'd0);
      chk("t3_sr", 32'(score_right), 32'd1);
      chk("t3_dir", 32'(serve_dir), 32'd1);
      chk("t3_point", 32'(state), 32'd3);
      repeat (3) tick();
      chk("t3_reserve", 32'(state), 32'd1);

      // 4: left player wins
      for (int k = 0; k < 3; k++) begin
         run_to_play();
         miss_right = 1; tick(); miss_right = 0;
      end
      repeat (3) tick();
      chk("t4_over", 32'(state), 32'd5);
      chk("t4_winner", 32'(winner), 32'd1);
      chk("t4_sl", 32'(score_left), 32'd3);
      chk("t4_model", 32'(m_phase), 32'd5);
      start = 1; tick(); start = 0;
      chk("t4_restart", 32'(state), 32'd1);
      chk("t4_sl0", 32'(score_left), 32'd0);
      chk("t4_win0", 32'(winner), 32'd0);

      // 5: pause during serve wait, then during play
      repeat (2) tick();
      pause_btn = 1; tick(); pause_btn = 0;
      chk("t5_paused", 32'(state), 32'd4);
      repeat (9) tick();
      chk("t5_still_paused", 32'(state), 32'd4);
      chk("t5_game_off", 32'(game_on), 32'd0);
      pause_btn = 1; tick(); pause_btn = 0;
      chk("t5_resume", 32'(state), 32'd1);
      chk("t5_no_serve0", 32'(serve), 32'd0);
      tick();
      chk("t5_wait2", 32'(state), 32'd1);
      tick();
      chk("t5_play", 32'(state), 32'd2);
      chk("t5_serve", 32'(serve), 32'd1);
      pause_btn = 1; tick(); pause_btn = 0;
      chk("t5_play_pause", 32'(state), 32'd4);
      tick();
      pause_btn = 1; tick(); pause_btn = 0;
      chk("t5_play_back", 32'(state), 32'd2);
      chk("t5_no_reserve", 32'(serve), 32'd0);
      tick();
      pause_btn = 1; miss_left = 1; tick();
      pause_btn = 0; miss_left = 0;
      chk("t5_miss_wins", 32'(state), 32'd3);
      chk("t5_miss_sr", 32'(score_right), 32'd1);

      // 6: reset mid-play with start held
      for (int k = 0; k < 2; k++) begin
         run_to_play();
         miss_right = 1; tick(); miss_right = 0;
      end
      run_to_play();
      chk("t6_sl2", 32'(score_left), 32'd2);
      chk("t6_sr1", 32'(score_right), 32'd1);
      start = 1; reset = 1; tick(); reset = 0;
      chk("t6_idle", 32'(state), 32'd0);
      chk("t6_sl0", 32'(score_left), 32'd0);
      chk("t6_sr0", 32'(score_right), 32'd0);
      chk("t6_game_off", 32'(game_on), 32'd0);
      repeat (3) tick();
      chk("t6_no_edge", 32'(state), 32'd0);
      start = 0; tick();

      // difficulty follows in idle, latched in match
      diff_sel = 2'd2; tick();
      chk("diff_follow", 32'(diff), 32'd2);
      start = 1; tick(); start = 0;
      diff_sel = 2'd1; tick();
      chk("diff_latched", 32'(diff), 32'd2);

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) start = ~start;
         if ($urandom_range(0, 9) == 0) pause_btn = ~pause_btn;
         miss_left  = ($urandom_range(0, 5) == 0);
         miss_right = ($urandom_range(0, 5) == 0);
         diff_sel   = 2'($urandom_range(0, 3));
         tick();
      end
      reset = 0;
      tick();

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
